// File: rtl/obj_dma_arbiter.sv
// Sprite DMA arbiter: freezes the 6502 by gating its clock enable, then copies LEN bytes of object RAM
// into the object store. Define OBJ_DMA_VBLANK_TRIG_EN to also start a burst on each rising edge of vblk.
module obj_dma_arbiter #(
    parameter logic [15:0] SRC_BASE  = 16'h0600,
    parameter int          LEN       = 256,
    parameter logic [15:0] TRIG_ADDR = 16'h2000,
    parameter int          RD_LAT    = 1
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        cen,
    input  logic [15:0] cpu_ab,
    input  logic        cpu_rw,
    input  logic        vblk,
    input  logic [7:0]  mem_din,
    output logic        cpu_cen,
    output logic [15:0] bus_ab,
    output logic        bus_rw,
    output logic        obj_we,
    output logic [7:0]  obj_addr,
    output logic [7:0]  obj_data,
    output logic        dma_busy,
    output logic        dma_done
);

    typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_DRAIN, ST_DONE} state_t;

    localparam logic [7:0]  IDX_LAST   = 8'(LEN - 1);
    localparam logic [15:0] LAST_AB    = 16'(SRC_BASE + LEN - 1);
    localparam logic [1:0]  DRAIN_LAST = 2'(RD_LAT - 1);

    state_t            state;
    logic [7:0]        idx;
    logic [1:0]        drain_cnt;
    logic [RD_LAT-1:0] v_pipe;
    logic [7:0]        i_pipe [RD_LAT];
    logic              trig;
    logic              start;
    logic              last_in;

    assign trig = cen & ~cpu_rw & (cpu_ab == TRIG_ADDR);

`ifdef OBJ_DMA_VBLANK_TRIG_EN
    logic vblk_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) vblk_q <= 1'b0;
        else          vblk_q <= vblk;
    end

    // A vblank edge and a CPU trigger in the same cycle merge into one start.
    assign start = trig | (vblk & ~vblk_q);
`else
    logic unused_vblk;
    assign unused_vblk = vblk;
    assign start       = trig;
`endif

    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            idx       <= 8'd0;
            drain_cnt <= 2'd0;
            dma_busy  <= 1'b0;
            dma_done  <= 1'b0;
        end else begin
            dma_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_XFER;
                        idx      <= 8'd0;
                        dma_busy <= 1'b1;
                    end
                end
                ST_XFER: begin
                    // With LEN=256 this increment wraps 255->0 exactly on the move to DRAIN.
                    idx <= idx + 8'd1;
                    if (idx == IDX_LAST) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= 2'd0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state    <= ST_DONE;
                        dma_busy <= 1'b0;
                        dma_done <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // mem_din is sampled on the edge that loads the last pipeline stage, so data for an
    // address issued in cycle C is taken at the end of cycle C+RD_LAT-1.
    generate
        if (RD_LAT == 1) begin : g_lat1
            assign last_in = (state == ST_XFER);
        end else begin : g_latn
            assign last_in = v_pipe[RD_LAT-2];
        end
    endgenerate

    // NOTE: the read pipeline is a handful of flops, so it is reset; an abort must not leave a pending write.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            v_pipe   <= '0;
            obj_data <= 8'd0;
            for (int k = 0; k < RD_LAT; k++) i_pipe[k] <= 8'd0;
        end else begin
            v_pipe[0] <= (state == ST_XFER);
            i_pipe[0] <= idx;
            for (int k = 1; k < RD_LAT; k++) begin
                v_pipe[k] <= v_pipe[k-1];
                i_pipe[k] <= i_pipe[k-1];
            end
            if (last_in) obj_data <= mem_din;
        end
    end

    assign obj_we   = v_pipe[RD_LAT-1];
    assign obj_addr = i_pipe[RD_LAT-1];

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        cpu_cen = cen;
        bus_ab  = cpu_ab;
        bus_rw  = cpu_rw;
        case (state)
            ST_XFER: begin
                cpu_cen = 1'b0;
                bus_ab  = SRC_BASE + {8'h00, idx};
                bus_rw  = 1'b1;
            end
            ST_DRAIN: begin
                cpu_cen = 1'b0;
                bus_ab  = LAST_AB;
                bus_rw  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_obj_dma_arbiter.sv
// Randomized bench for obj_dma_arbiter: a short-burst instance (LEN=4, RD_LAT=1) and a full-length one
// (LEN=256, RD_LAT=2) share the CPU stimulus and are compared every cycle against a timeline model.
module tb_obj_dma_arbiter;

    localparam logic [15:0] SRC   = 16'h0600;
    localparam logic [15:0] TRIG  = 16'h2000;
    localparam int          LEN_A = 4;
    localparam int          LAT_A = 1;
    localparam int          LEN_B = 256;
    localparam int          LAT_B = 2;
    localparam int          T_IDLE = -1000000;
`ifdef OBJ_DMA_VBLANK_TRIG_EN
    localparam int VB_EN = 1;
`else
    localparam int VB_EN = 0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        cen     = 1'b0;
    logic [15:0] cpu_ab  = 16'h0000;
    logic        cpu_rw  = 1'b1;
    logic        vblk    = 1'b0;

    logic [7:0]  mem_din_a, mem_din_b;
    logic        cpu_cen_a, bus_rw_a, obj_we_a, dma_busy_a, dma_done_a;
    logic        cpu_cen_b, bus_rw_b, obj_we_b, dma_busy_b, dma_done_b;
    logic [15:0] bus_ab_a, bus_ab_b;
    logic [7:0]  obj_addr_a, obj_data_a, obj_addr_b, obj_data_b;

    always #5 clk_sys = ~clk_sys;

    obj_dma_arbiter #(.SRC_BASE(SRC), .LEN(LEN_A), .TRIG_ADDR(TRIG), .RD_LAT(LAT_A)) u_dut_a (
        .clk_sys(clk_sys), .reset_n(reset_n), .cen(cen), .cpu_ab(cpu_ab), .cpu_rw(cpu_rw),
        .vblk(vblk), .mem_din(mem_din_a), .cpu_cen(cpu_cen_a), .bus_ab(bus_ab_a), .bus_rw(bus_rw_a),
        .obj_we(obj_we_a), .obj_addr(obj_addr_a), .obj_data(obj_data_a),
        .dma_busy(dma_busy_a), .dma_done(dma_done_a)
    );

    obj_dma_arbiter #(.SRC_BASE(SRC), .LEN(LEN_B), .TRIG_ADDR(TRIG), .RD_LAT(LAT_B)) u_dut_b (
        .clk_sys(clk_sys), .reset_n(reset_n), .cen(cen), .cpu_ab(cpu_ab), .cpu_rw(cpu_rw),
        .vblk(vblk), .mem_din(mem_din_b), .cpu_cen(cpu_cen_b), .bus_ab(bus_ab_b), .bus_rw(bus_rw_b),
        .obj_we(obj_we_b), .obj_addr(obj_addr_b), .obj_data(obj_data_b),
        .dma_busy(dma_busy_b), .dma_done(dma_done_b)
    );

    // Memory image: combinational read for A, one-cycle synchronous read for B.
    logic [7:0] mem [0:65535];
    assign mem_din_a = mem[bus_ab_a];
    always @(posedge clk_sys) mem_din_b <= mem[bus_ab_b];

    typedef struct packed {
        logic        cpu_cen;
        logic [15:0] bus_ab;
        logic        bus_rw;
        logic        obj_we;
        logic [7:0]  obj_addr;
        logic        busy;
        logic        done;
    } exp_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0_a    = T_IDLE;
    int t0_b    = T_IDLE;
    logic vblk_prev = 1'b0;

    int we_a, done_a, cen0_a, we_b, done_b, busy_b;
    logic [15:0] last_ab_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected outputs k cycles after the cycle in which a burst was accepted.
    function automatic exp_t model(input int k, input int len, input int lat);
        exp_t e;
        e = '0;
        e.cpu_cen = cen;
        e.bus_ab  = cpu_ab;
        e.bus_rw  = cpu_rw;
        if (k >= 1 && k <= len) begin
            e.cpu_cen = 1'b0;
            e.bus_ab  = 16'(SRC + k - 1);
            e.bus_rw  = 1'b1;
            e.busy    = 1'b1;
        end else if (k > len && k <= len + lat) begin
            e.cpu_cen = 1'b0;
            e.bus_ab  = 16'(SRC + len - 1);
            e.bus_rw  = 1'b1;
            e.busy    = 1'b1;
        end else if (k == len + lat + 1) begin
            e.done = 1'b1;
        end
        if (k >= lat + 1 && k <= len + lat) begin
            e.obj_we   = 1'b1;
            e.obj_addr = 8'(k - lat - 1);
        end
        return e;
    endfunction

    function automatic bit is_idle(input int t0, input int len, input int lat);
        return (cyc - t0) > (len + lat + 1);
    endfunction

    function automatic logic [15:0] rand_ab();
        logic [15:0] a;
        a = 16'($urandom);
        if (a == TRIG) a = a ^ 16'h0001;
        return a;
    endfunction

    task automatic check_dut(input string nm, input exp_t e, input logic c, input logic [15:0] ab,
                             input logic rw, input logic we, input logic [7:0] addr,
                             input logic [7:0] data, input logic busy, input logic done);
        check({nm, ".cpu_cen"}, c, e.cpu_cen);
        check({nm, ".bus_ab"}, ab, e.bus_ab);
        check({nm, ".bus_rw"}, rw, e.bus_rw);
        check({nm, ".obj_we"}, we, e.obj_we);
        check({nm, ".dma_busy"}, busy, e.busy);
        check({nm, ".dma_done"}, done, e.done);
        if (e.obj_we) begin
            check({nm, ".obj_addr"}, addr, e.obj_addr);
            check({nm, ".obj_data"}, data, mem[16'(SRC + e.obj_addr)]);
        end
    endtask

    task automatic clear_counts();
        we_a = 0; done_a = 0; cen0_a = 0;
        we_b = 0; done_b = 0; busy_b = 0;
        last_ab_b = 16'h0000;
    endtask

    // One clock: check at the falling edge, advance the model on the rising edge, return at posedge+1.
    task automatic step();
        exp_t ea, eb;
        bit   fire;
        @(negedge clk_sys);
        ea = model(cyc - t0_a, LEN_A, LAT_A);
        eb = model(cyc - t0_b, LEN_B, LAT_B);
        check_dut("a", ea, cpu_cen_a, bus_ab_a, bus_rw_a, obj_we_a, obj_addr_a, obj_data_a,
                  dma_busy_a, dma_done_a);
        check_dut("b", eb, cpu_cen_b, bus_ab_b, bus_rw_b, obj_we_b, obj_addr_b, obj_data_b,
                  dma_busy_b, dma_done_b);
        we_a   += int'(obj_we_a);
        done_a += int'(dma_done_a);
        cen0_a += int'(!cpu_cen_a);
        we_b   += int'(obj_we_b);
        done_b += int'(dma_done_b);
        busy_b += int'(dma_busy_b);
        if (dma_busy_b) last_ab_b = bus_ab_b;

        fire = cen && !cpu_rw && (cpu_ab == TRIG);
        if (VB_EN != 0 && vblk && !vblk_prev) fire = 1'b1;
        if (reset_n) begin
            if (fire && is_idle(t0_a, LEN_A, LAT_A)) t0_a = cyc;
            if (fire && is_idle(t0_b, LEN_B, LAT_B)) t0_b = cyc;
            vblk_prev = vblk;
        end else begin
            vblk_prev = 1'b0;
        end
        @(posedge clk_sys);
        cyc++;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        clear_counts();

        // Reset state
        repeat (3) step();
        check("rst.obj_addr_a", obj_addr_a, 8'd0);
        check("rst.obj_data_a", obj_data_a, 8'd0);
        check("rst.obj_addr_b", obj_addr_b, 8'd0);
        check("rst.obj_data_b", obj_data_b, 8'd0);
        reset_n = 1'b1;
        repeat (2) step();

        // Basic trigger, freeze with cen every cycle, retrigger in XFER and in A's DONE cycle
        cen = 1'b1; cpu_rw = 1'b0; cpu_ab = TRIG;
        step();
        clear_counts();
        for (int j = 1; j <= 270; j++) begin
            cen    = 1'b1;
            cpu_rw = 1'($urandom_range(0, 1));
            cpu_ab = rand_ab();
            if (j == 2 || j == 6) begin
                cpu_rw = 1'b0;
                cpu_ab = TRIG;
            end
            step();
        end
        check("basic.we_count_a", we_a, LEN_A);
        check("basic.done_count_a", done_a, 1);
        check("freeze.cen_held_a", cen0_a, LEN_A + LAT_A);
        check("full.we_count_b", we_b, LEN_B);
        check("full.busy_cycles_b", busy_b, LEN_B + LAT_B);
        check("full.done_count_b", done_b, 1);
        check("full.last_bus_ab_b", last_ab_b, 16'h06FF);

        // Randomized traffic
        for (int j = 0; j < 3000; j++) begin
            cen    = ($urandom_range(0, 3) != 0);
            cpu_rw = 1'($urandom_range(0, 1));
            cpu_ab = ($urandom_range(0, 7) == 0) ? TRIG : rand_ab();
            if ($urandom_range(0, 99) == 0) vblk = ~vblk;
            step();
        end

        // Let both engines go idle (bounded) before the reset-abort test
        cen = 1'b1; cpu_rw = 1'b1; cpu_ab = 16'h0000; vblk = 1'b0;
        for (int g = 0; g < 600 && !(is_idle(t0_a, LEN_A, LAT_A) && is_idle(t0_b, LEN_B, LAT_B)); g++)
            step();
        check("drain.idle", int'(is_idle(t0_a, LEN_A, LAT_A) && is_idle(t0_b, LEN_B, LAT_B)), 1);
        step();

        // Reset abort at idx=2
        cpu_rw = 1'b0; cpu_ab = TRIG;
        step();
        cpu_rw = 1'b1; cpu_ab = 16'h0000;
        step();
        step();
        reset_n = 1'b0;
        t0_a = T_IDLE;
        t0_b = T_IDLE;
        clear_counts();
        for (int j = 0; j < 2; j++) begin
            cen = 1'($urandom_range(0, 1)); cpu_rw = 1'($urandom_range(0, 1)); cpu_ab = rand_ab();
            step();
        end
        reset_n = 1'b1;
        for (int j = 0; j < 20; j++) begin
            cen = 1'($urandom_range(0, 1)); cpu_rw = 1'($urandom_range(0, 1)); cpu_ab = rand_ab();
            step();
        end
        check("abort.we_a", we_a, 0);
        check("abort.done_a", done_a, 0);
        check("abort.we_b", we_b, 0);
        check("abort.done_b", done_b, 0);

        // vblank trigger: one burst per rising edge, none while held high
        cen = 1'b1; cpu_rw = 1'b1; cpu_ab = 16'h0000; vblk = 1'b0;
        step();
        clear_counts();
        vblk = 1'b1;
        repeat (600) step();
        check("vblank.done_a", done_a, VB_EN);
        check("vblank.done_b", done_b, VB_EN);
        check("vblank.we_b", we_b, VB_EN * LEN_B);
        vblk = 1'b0;
        step();
        clear_counts();
        vblk = 1'b1;
        repeat (270) step();
        check("vblank2.done_b", done_b, VB_EN);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
